// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dmem_arbiter
// Brief   : Round-robin share of a single-port data memory between LSU and fetch.
// Revision: 1.0
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lsu_cs,
    input  logic                lsu_wr,
    input  logic [DATA_W/8-1:0] lsu_mask,
    input  logic [ADDR_W-1:0]   lsu_addr,
    input  logic [DATA_W-1:0]   lsu_wdata,
    output logic [DATA_W-1:0]   lsu_rdata,
    output logic                lsu_stall,
    output logic                lsu_valid,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    output logic                if_valid,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_mask,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_ready,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int MASK_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    localparam logic OWN_IF  = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              owner_q;
    logic              last_grant_q;
    logic              withdrawn_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [MASK_W-1:0] mem_mask_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic [DATA_W-1:0] lsu_rdata_q;
    logic [DATA_W-1:0] if_rdata_q;
    logic              lsu_valid_q;
    logic              if_valid_q;

    logic w_lsu_req;
    logic w_if_req;
    logic w_grant_lsu;
    logic w_owner_req;
    logic w_in_resp;

    assign w_lsu_req   = ~lsu_cs;
    assign w_if_req    = if_req;
    // On a conflict the requester that was not served last wins.
    assign w_grant_lsu = w_lsu_req & (~w_if_req | (last_grant_q == OWN_IF));
    assign w_owner_req = (owner_q == OWN_LSU) ? w_lsu_req : w_if_req;
    assign w_in_resp   = (state_q == S_RESP);

    assign lsu_stall = w_lsu_req & ~(w_in_resp & (owner_q == OWN_LSU));
    assign if_stall  = w_if_req  & ~(w_in_resp & (owner_q == OWN_IF));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (w_lsu_req | w_if_req) state_d = S_REQ;
            S_REQ:   if (mem_ready)            state_d = S_WAIT;
            S_WAIT:  if (mem_rvalid)           state_d = S_RESP;
            S_RESP:                            state_d = S_IDLE;
            default:                           state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= OWN_IF;
            last_grant_q <= OWN_IF;
            withdrawn_q  <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_mask_q   <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            lsu_rdata_q  <= '0;
            if_rdata_q   <= '0;
            lsu_valid_q  <= 1'b0;
            if_valid_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            lsu_valid_q <= 1'b0;
            if_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (w_lsu_req | w_if_req) begin
                        owner_q     <= w_grant_lsu ? OWN_LSU : OWN_IF;
                        withdrawn_q <= 1'b0;
                        mem_req_q   <= 1'b1;
                        if (w_grant_lsu) begin
                            mem_we_q    <= ~lsu_wr;
                            mem_mask_q  <= lsu_mask;
                            mem_addr_q  <= lsu_addr;
                            mem_wdata_q <= lsu_wdata;
                        end else begin
                            mem_we_q    <= 1'b0;
                            mem_mask_q  <= {MASK_W{1'b1}};
                            mem_addr_q  <= if_addr;
                            mem_wdata_q <= '0;
                        end
                    end
                end
                S_REQ: begin
                    if (!w_owner_req) withdrawn_q <= 1'b1;
                    if (mem_ready)    mem_req_q   <= 1'b0;
                end
                S_WAIT: begin
                    if (!w_owner_req) withdrawn_q <= 1'b1;
                    if (mem_rvalid) begin
                        // A flushed owner still gets its data, but no completion pulse.
                        if (owner_q == OWN_LSU) begin
                            if (!mem_we_q) lsu_rdata_q <= mem_rdata;
                            lsu_valid_q <= ~withdrawn_q & w_owner_req;
                        end else begin
                            if (!mem_we_q) if_rdata_q <= mem_rdata;
                            if_valid_q <= ~withdrawn_q & w_owner_req;
                        end
                    end
                end
                S_RESP: begin
                    last_grant_q <= owner_q;
                end
                default: begin
                    mem_req_q <= 1'b0;
                end
            endcase
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_mask  = mem_mask_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign lsu_rdata = lsu_rdata_q;
    assign if_rdata  = if_rdata_q;
    assign lsu_valid = lsu_valid_q;
    assign if_valid  = if_valid_q;

endmodule
`default_nettype wire
